data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15; number of added wait cycles before each access.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 address  input  32  byte address from initiator; bits [1:0] ignored; word index = address[ADDR_W+1:2]; higher bits ignored (wrap).
REQ-006 read  input  1  read request.
REQ-007 write  input  1  write request.
REQ-008 byteenable  input  4  active lanes; bit i selects data bits [8i+7:8i].
REQ-009 writedata  input  32  write data, lane-aligned.
REQ-010 readdata  output  32  read data, full word; initiator applies lane selection.
REQ-011 waitrequest  output  1  high = request not yet accepted.
REQ-012 err  output  1  one-cycle pulse flagging a rejected access (see Configuration).

Function
REQ-013 States: IDLE, WAIT, ACCESS.
REQ-014 waitrequest = (read | write) & (state != ACCESS), combinational; low when no request.
REQ-015 IDLE with read|write high: go to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else go directly to ACCESS.
REQ-016 WAIT: decrement counter each cycle; at counter 0 go to ACCESS.
REQ-017 ACCESS lasts exactly one cycle; access performed at its closing edge; next state IDLE.
REQ-018 Accept latency: waitrequest high for WAIT_CYCLES+1 cycles, low for 1 cycle; back-to-back requests re-enter WAIT from IDLE.
REQ-019 Write: at the ACCESS closing edge, update only lanes with byteenable=1; other lanes retain their old value.
REQ-020 Read: at the ACCESS closing edge, readdata <= stored word; readdata holds until the next read completes.
REQ-021 Writes do not alter readdata.
REQ-022 read and write both high: write performed, readdata unchanged.
REQ-023 Request dropped while in WAIT (protocol violation): return to IDLE, no access, no err.
REQ-024 Initiator holds address, byteenable and writedata stable while waitrequest is high; responder samples them in ACCESS only.

Reset
REQ-025 reset low: state=IDLE, counter=0, readdata=0, err=0, asynchronously; memory contents not reset.
REQ-026 Reset asserted mid-WAIT or mid-ACCESS: access aborted, no memory write.

Configuration
REQ-027 Macro DATA_MEM_RESPONDER_BE_CHECK_EN defined: byteenable not one of {0001,0010,0100,1000,0011,0110,1100,0111,1110,1111} is illegal.
REQ-028 An illegal access still completes the handshake, but suppresses the write, leaves readdata unchanged, and pulses err high during the cycle after ACCESS.
REQ-029 Macro undefined: no checking; err tied to 0; all byteenable values execute per REQ-019/020 (0000 write is a no-op).

Structure
REQ-030 Package mips_mem_pkg holds the state enum (IDLE/WAIT/ACCESS), the legal-byteenable list/function, and the lane-width constant 8.
REQ-031 One sub-module, data_mem_array: 2**ADDR_W x 32 array with a 4-bit lane-write enable and a synchronous read port; the FSM stays in data_mem_responder.

Verification
REQ-032 WAIT_CYCLES=1; write 0xDEADBEEF, byteenable 1111, address 0x10 -> waitrequest high 2 cycles then low 1; a subsequent read of 0x10 returns readdata 0xDEADBEEF.
REQ-033 After REQ-032, write 0x00AB0000, byteenable 0100, address 0x12 -> a read of 0x10 returns 0xDEABBEEF.
REQ-034 WAIT_CYCLES=0; read 0x10 -> waitrequest high exactly 1 cycle; readdata valid after the ACCESS edge.
REQ-035 Read and write both high, address 0x20, writedata 0x12345678 -> word updated, readdata unchanged; reset pulsed during the WAIT of a following write to 0x20 -> word still 0x12345678.
REQ-036 BE_CHECK_EN defined; write byteenable 0101 to 0x30 -> handshake completes, err pulses 1 cycle, word unchanged. Macro undefined: same stimulus writes lanes 0 and 2, and err stays 0.
REQ-037 ADDR_W=10; write to address 0x1000 -> aliases word 0 (wrap-around).

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// lane geometry and the table of byteenable patterns the initiator may legally issue.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } mem_state_t;

  localparam int unsigned LANE_W       = 8;
  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned NUM_LEGAL_BE = 10;

  // Contiguous lane groups only: bytes, aligned/unaligned halfwords, 3-byte runs, full word.
  localparam logic [3:0] LEGAL_BE [NUM_LEGAL_BE] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0011, 4'b0110, 4'b1100,
    4'b0111, 4'b1110, 4'b1111
  };

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_BE; i++) begin
      if (be == LEGAL_BE[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage with per-lane write enables and a registered read port;
// the read register is the only resettable state here, the array itself is not reset.
module data_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (we[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

  // Holds the last word read; writes never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data-memory slave: IDLE -> WAIT (WAIT_CYCLES) -> ACCESS handshake.
// Optional byteenable legality checking via `define DATA_MEM_RESPONDER_BE_CHECK_EN.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        err
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              req;
  logic              in_access;
  logic              be_ok;
  logic [3:0]        mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;

  assign req              = read | write;
  assign in_access        = (state == ACCESS);
  assign waitrequest      = req & ~in_access;
  assign word_idx         = address[ADDR_W+1:2];
  assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAIT: begin
        // A request withdrawn mid-wait is abandoned silently.
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ACCESS;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DATA_MEM_RESPONDER_BE_CHECK_EN
  assign be_ok = be_legal(byteenable);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= in_access & req & ~be_ok;
    end
  end
`else
  assign be_ok = 1'b1;
  assign err   = 1'b0;
`endif

  // Write takes priority when read and write are both asserted.
  assign mem_we = (in_access & write & be_ok) ? byteenable : 4'b0000;
  assign mem_re = in_access & read & ~write & be_ok;

  data_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst_n(reset),
    .addr (word_idx),
    .we   (mem_we),
    .wdata(writedata),
    .re   (mem_re),
    .rdata(readdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses WAIT_CYCLES=1, instance 1 WAIT_CYCLES=0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [3:0]  be_s   [2];
  logic [31:0] rdd_s  [2];
  logic        wreq_s [2];
  logic        err_s  [2];

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(rst_s[0]), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
    .byteenable(be_s[0]), .writedata(wd_s[0]), .readdata(rdd_s[0]),
    .waitrequest(wreq_s[0]), .err(err_s[0])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_s[1]), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
    .byteenable(be_s[1]), .writedata(wd_s[1]), .readdata(rdd_s[1]),
    .waitrequest(wreq_s[1]), .err(err_s[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] model   [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] sb_q [$];

  function automatic logic tb_be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100,
      4'b0111, 4'b1110, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Full handshake from a negedge; expected readdata goes through the scoreboard queue.
  task automatic access(input int s, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d, input string tag);
    int          n;
    logic        legal;
    int unsigned idx;
    legal = 1'b1;
`ifdef DATA_MEM_RESPONDER_BE_CHECK_EN
    legal = tb_be_legal(be);
`endif
    idx = (a >> 2) & 32'h3FF;
    rd_s[s] = r; wr_s[s] = w; addr_s[s] = a; be_s[s] = be; wd_s[s] = d;
    n = 0;
    while (n < 40) begin
      #1;
      if (!wreq_s[s]) break;
      n++;
      @(negedge clk);
    end
    check({tag, "_wait"}, 32'(n), (s == 0) ? 32'd2 : 32'd1);
    if (w && legal) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
    end
    if (r && !w && legal) last_rd[s] = model[s][idx];
    sb_q.push_back(last_rd[s]);
    @(posedge clk);
    #1;
    rd_s[s] = 1'b0; wr_s[s] = 1'b0;
    @(negedge clk);
    check({tag, "_rdata"}, rdd_s[s], sb_q.pop_front());
    check({tag, "_err"}, {31'b0, err_s[s]}, {31'b0, (r | w) & ~legal});
    @(negedge clk);
    check({tag, "_err_clr"}, {31'b0, err_s[s]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b0; rd_s[s] = 1'b0; wr_s[s] = 1'b0;
      addr_s[s] = '0; wd_s[s] = '0; be_s[s] = '0; last_rd[s] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_rdata0", rdd_s[0], 32'd0);
    check("rst_err0",   {31'b0, err_s[0]}, 32'd0);
    check("rst_wreq0",  {31'b0, wreq_s[0]}, 32'd0);
    check("rst_rdata1", rdd_s[1], 32'd0);
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    @(negedge clk);

    access(0, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, "wr_full");
    access(0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, "rd_full");
    check("lit_deadbeef", rdd_s[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h12, 4'b0100, 32'h00AB0000, "wr_lane2");
    access(0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, "rd_merged");
    check("lit_deabbeef", rdd_s[0], 32'hDEABBEEF);

    access(1, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, "w0_wr");
    access(1, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, "w0_rd");
    check("lit_cafef00d", rdd_s[1], 32'hCAFEF00D);
    access(1, 1'b0, 1'b1, 32'h14, 4'b1111, 32'h01020304, "w0_wr_keep");

    access(0, 1'b1, 1'b1, 32'h20, 4'b1111, 32'h12345678, "rw_both");

    // Reset during the WAIT of a write to 0x20 must leave the word intact.
    addr_s[0] = 32'h20; wd_s[0] = 32'hFFFFFFFF; be_s[0] = 4'b1111; wr_s[0] = 1'b1;
    @(posedge clk);
    #2;
    rst_s[0] = 1'b0;
    #1;
    check("midwait_rst_rdata", rdd_s[0], 32'd0);
    @(negedge clk);
    wr_s[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_s[0] = 1'b1;
    last_rd[0] = '0;
    @(negedge clk);
    access(0, 1'b1, 1'b0, 32'h20, 4'b1111, 32'h0, "rd_after_rst");
    check("lit_12345678", rdd_s[0], 32'h12345678);

    access(0, 1'b0, 1'b1, 32'h30, 4'b1111, 32'hAAAAAAAA, "wr_30");
    access(0, 1'b0, 1'b1, 32'h30, 4'b0101, 32'h11223344, "wr_be0101");
    access(0, 1'b1, 1'b0, 32'h30, 4'b1111, 32'h0, "rd_30");
`ifdef DATA_MEM_RESPONDER_BE_CHECK_EN
    check("lit_30", rdd_s[0], 32'hAAAAAAAA);
`else
    check("lit_30", rdd_s[0], 32'hAA22AA44);
`endif

    access(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h55555555, "wr_be0000");
    access(0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, "rd_be0000");

    access(0, 1'b0, 1'b1, 32'h1000, 4'b1111, 32'h5A5A1234, "wr_wrap");
    access(0, 1'b1, 1'b0, 32'h0, 4'b1111, 32'h0, "rd_wrap");
    check("lit_wrap", rdd_s[0], 32'h5A5A1234);

    // Request withdrawn while in WAIT: no write, no err.
    addr_s[0] = 32'h10; wd_s[0] = 32'h0; be_s[0] = 4'b1111; wr_s[0] = 1'b1;
    @(posedge clk);
    #1;
    wr_s[0] = 1'b0;
    @(negedge clk);
    check("drop_wreq", {31'b0, wreq_s[0]}, 32'd0);
    @(negedge clk);
    check("drop_err", {31'b0, err_s[0]}, 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0, "rd_after_drop");
    check("lit_after_drop", rdd_s[0], 32'hDEABBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
